// File: rtl/dshot_processing.sv
`default_nettype none
// ============================================================================
//  Module   : dshot_processing
//  Purpose  : Decodes one 16-bit DShot frame per frameValid strobe into a
//             throttle value or a special-command number. It checks the
//             frame's 4-bit CRC and keeps a saturating count of bad-CRC
//             frames.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   1   rising-edge clock
//    rst              in   1   asynchronous active-high reset
//    rawData          in  16   [15:5] throttle, [4] telemetry req, [3:0] CRC
//    frameValid       in   1   single-cycle strobe, rawData sampled with it
//    setSpeed         out 11   throttle of last good speed frame, else 0
//    specialCommand   out  6   command of last good special frame, else 0
//    isSpecialCommand out  1   last frame good CRC and throttle < 48
//    CRCValid         out  1   last frame CRC matched
//    isValidSpeed     out  1   last frame good CRC and throttle >= 48
//    telemetryBit     out  1   telemetry bit of last frame if CRC good
//    outValid         out  1   pulse in the cycle after each sampled frame
//    crcErrorCount    out  8   saturating bad-CRC frame count
// ============================================================================
module dshot_processing (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rawData,
    input  logic        frameValid,
    output logic [10:0] setSpeed,
    output logic [5:0]  specialCommand,
    output logic        isSpecialCommand,
    output logic        CRCValid,
    output logic        isValidSpeed,
    output logic        telemetryBit,
    output logic        outValid,
    output logic [7:0]  crcErrorCount
);

    localparam logic [10:0] SPECIAL_LIMIT = 11'd48;
    localparam logic [7:0]  COUNT_MAX     = 8'hFF;

    logic [11:0] value_field;
    logic [10:0] throttle;
    logic [3:0]  crc_expected;
    logic        crc_ok;
    logic        is_special;

    assign value_field  = rawData[15:4];
    assign throttle     = rawData[15:5];
    // XOR of the three nibbles of the value field equals the low nibble of
    // v ^ (v >> 4) ^ (v >> 8).
    assign crc_expected = value_field[3:0] ^ value_field[7:4] ^ value_field[11:8];
    assign crc_ok       = (crc_expected == rawData[3:0]);
    assign is_special   = (throttle < SPECIAL_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setSpeed         <= '0;
            specialCommand   <= '0;
            isSpecialCommand <= 1'b0;
            CRCValid         <= 1'b0;
            isValidSpeed     <= 1'b0;
            telemetryBit     <= 1'b0;
            outValid         <= 1'b0;
            crcErrorCount    <= '0;
        end else begin
            outValid <= frameValid;
            if (frameValid) begin
                // Every decoded field is rewritten per frame, so nothing
                // except the error counter survives from one frame to the next.
                CRCValid         <= crc_ok;
                isValidSpeed     <= crc_ok && !is_special;
                isSpecialCommand <= crc_ok && is_special;
                setSpeed         <= (crc_ok && !is_special) ? throttle : 11'd0;
                specialCommand   <= (crc_ok && is_special) ? throttle[5:0] : 6'd0;
                telemetryBit     <= crc_ok && rawData[4];
                if (!crc_ok && (crcErrorCount != COUNT_MAX)) begin
                    crcErrorCount <= crcErrorCount + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dshot_processing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dshot_processing
//  Purpose  : Self-checking bench for dshot_processing. Expected values come
//             from an arithmetic model of the DShot frame rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dshot_processing;

    logic        clk;
    logic        rst;
    logic [15:0] rawData;
    logic        frameValid;
    logic [10:0] setSpeed;
    logic [5:0]  specialCommand;
    logic        isSpecialCommand;
    logic        CRCValid;
    logic        isValidSpeed;
    logic        telemetryBit;
    logic        outValid;
    logic [7:0]  crcErrorCount;

    int checks   = 0;
    int failures = 0;

    // Model expectations
    int e_speed, e_cmd, e_spec, e_crc, e_vs, e_tel, e_cnt;

    dshot_processing dut (
        .clk              (clk),
        .rst              (rst),
        .rawData          (rawData),
        .frameValid       (frameValid),
        .setSpeed         (setSpeed),
        .specialCommand   (specialCommand),
        .isSpecialCommand (isSpecialCommand),
        .CRCValid         (CRCValid),
        .isValidSpeed     (isValidSpeed),
        .telemetryBit     (telemetryBit),
        .outValid         (outValid),
        .crcErrorCount    (crcErrorCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] observed();
        return {setSpeed, specialCommand, isSpecialCommand, CRCValid,
                isValidSpeed, telemetryBit, outValid, crcErrorCount};
    endfunction

    function automatic logic [29:0] expected(input logic ov);
        logic [10:0] sp;
        logic [5:0]  cm;
        logic [7:0]  cn;
        sp = 11'(e_speed);
        cm = 6'(e_cmd);
        cn = 8'(e_cnt);
        return {sp, cm, e_spec[0], e_crc[0], e_vs[0], e_tel[0], ov, cn};
    endfunction

    function automatic int crc_of(input int raw);
        int v;
        v = (raw >> 4) & 12'hFFF;
        return (v ^ (v >> 4) ^ (v >> 8)) & 4'hF;
    endfunction

    // Frame rules applied to the model state.
    task automatic model(input logic [15:0] raw);
        int t;
        t = raw >> 5;
        if (crc_of(raw) == int'(raw[3:0])) begin
            e_crc  = 1;
            e_tel  = raw[4];
            e_vs   = (t >= 48) ? 1 : 0;
            e_spec = (t >= 48) ? 0 : 1;
            e_speed = (t >= 48) ? t : 0;
            e_cmd   = (t >= 48) ? 0 : t;
        end else begin
            e_crc = 0; e_tel = 0; e_vs = 0; e_spec = 0; e_speed = 0; e_cmd = 0;
            e_cnt = (e_cnt >= 255) ? 255 : e_cnt + 1;
        end
    endtask

    task automatic model_clear();
        e_speed = 0; e_cmd = 0; e_spec = 0; e_crc = 0; e_vs = 0; e_tel = 0; e_cnt = 0;
    endtask

    // Present one frame at a negedge, strobe one cycle; returns at the
    // following negedge with the decoded outputs settled and outValid high.
    task automatic send(input logic [15:0] raw);
        @(negedge clk);
        rawData    = raw;
        frameValid = 1'b1;
        @(negedge clk);
        frameValid = 1'b0;
        model(raw);
    endtask

    function automatic logic [15:0] make_good(input logic [15:0] raw);
        logic [15:0] r;
        r = raw;
        r[3:0] = 4'(crc_of(raw));
        return r;
    endfunction

    function automatic logic [15:0] make_bad(input logic [15:0] raw);
        logic [15:0] r;
        r = raw;
        r[3:0] = 4'(crc_of(raw)) ^ 4'($urandom_range(1, 15));
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rawData = 16'h82C6;
        frameValid = 1'b1;          // must be discarded during reset
        repeat (3) @(negedge clk);
        checks++;
        if (observed() !== 30'd0) begin
            failures++;
            $display("FAIL reset_hold actual=%h required=%h", observed(), 30'd0);
        end
        frameValid = 1'b0;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (observed() !== 30'd0) begin
            failures++;
            $display("FAIL reset_release actual=%h required=%h", observed(), 30'd0);
        end
    endtask

    task automatic test_directed();
        send(16'h82C6);
        checks++;
        if (observed() !== {11'd1046, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL speed_82C6 actual=%h required=%h", observed(),
                     {11'd1046, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
        end
        send(16'h82C5);
        checks++;
        if (observed() !== {11'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL badcrc_82C5 actual=%h required=%h", observed(),
                     {11'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        end
        send(16'hDEAD);
        checks++;
        if (CRCValid !== 1'b0 || crcErrorCount !== 8'd2) begin
            failures++;
            $display("FAIL badcrc_DEAD actual=%b/%0d required=0/2", CRCValid, crcErrorCount);
        end
        send(16'hDEA9);
        checks++;
        if (observed() !== {11'd1781, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2}) begin
            failures++;
            $display("FAIL speed_DEA9 actual=%h required=%h", observed(),
                     {11'd1781, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2});
        end
        send(16'hBEEF);
        checks++;
        if (CRCValid !== 1'b0 || crcErrorCount !== 8'd3) begin
            failures++;
            $display("FAIL badcrc_BEEF actual=%b/%0d required=0/3", CRCValid, crcErrorCount);
        end
        send(16'h00BB);
        checks++;
        if (observed() !== {11'd0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3}) begin
            failures++;
            $display("FAIL special_00BB actual=%h required=%h", observed(),
                     {11'd0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3});
        end
        // Boundaries: t=0 is command 0, t=47 special, t=48 speed, t=2047 speed.
        send(make_good({11'd0, 5'd0}));
        checks++;
        if (observed() !== expected(1'b1) || isSpecialCommand !== 1'b1) begin
            failures++;
            $display("FAIL special_t0 actual=%h required=%h", observed(), expected(1'b1));
        end
        send(make_good({11'd47, 5'd0}));
        checks++;
        if (observed() !== expected(1'b1) || specialCommand !== 6'd47) begin
            failures++;
            $display("FAIL special_t47 actual=%h required=%h", observed(), expected(1'b1));
        end
        send(make_good({11'd48, 5'h10}));
        checks++;
        if (observed() !== expected(1'b1) || setSpeed !== 11'd48) begin
            failures++;
            $display("FAIL speed_t48 actual=%h required=%h", observed(), expected(1'b1));
        end
        send(make_good({11'd2047, 5'd0}));
        checks++;
        if (observed() !== expected(1'b1) || setSpeed !== 11'd2047) begin
            failures++;
            $display("FAIL speed_t2047 actual=%h required=%h", observed(), expected(1'b1));
        end
    endtask

    task automatic test_hold();
        send(make_good(16'h5A30));
        repeat (4) begin
            @(negedge clk);
            rawData = 16'($urandom);
            @(negedge clk);
            checks++;
            if (observed() !== expected(1'b0)) begin
                failures++;
                $display("FAIL hold actual=%h required=%h", observed(), expected(1'b0));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] raw;
        for (int i = 0; i < 200; i++) begin
            raw = 16'($urandom);
            case ($urandom_range(0, 3))
                0: raw = make_good(raw);
                1: raw = make_good({11'($urandom_range(0, 47)), raw[4:0]});
                2: raw = make_bad(raw);
                default: ;
            endcase
            send(raw);
            checks++;
            if (observed() !== expected(1'b1)) begin
                failures++;
                $display("FAIL random raw=%h actual=%h required=%h", raw, observed(), expected(1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] raw;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            raw = (i % 3 == 2) ? make_bad(16'($urandom)) : make_good(16'($urandom));
            rawData    = raw;
            frameValid = 1'b1;
            @(negedge clk);
            model(raw);
            checks++;
            if (observed() !== expected(1'b1)) begin
                failures++;
                $display("FAIL back_to_back raw=%h actual=%h required=%h", raw, observed(), expected(1'b1));
            end
        end
        frameValid = 1'b0;
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("FAIL outvalid_drop actual=%b required=0", outValid);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] raw;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            raw = make_bad(16'($urandom));
            rawData    = raw;
            frameValid = 1'b1;
            @(negedge clk);
            model(raw);
        end
        frameValid = 1'b0;
        checks++;
        if (crcErrorCount !== 8'd255 || observed() !== expected(1'b1)) begin
            failures++;
            $display("FAIL saturate actual=%h required=%h", observed(), expected(1'b1));
        end
        send(make_bad(16'h1234));
        checks++;
        if (crcErrorCount !== 8'd255) begin
            failures++;
            $display("FAIL saturate_stay actual=%0d required=255", crcErrorCount);
        end
    endtask

    task automatic test_async_reset();
        send(make_good(16'h82C6));
        #2;
        rst = 1'b1;                 // between edges: effect must be immediate
        #1;
        model_clear();
        checks++;
        if (observed() !== 30'd0) begin
            failures++;
            $display("FAIL async_reset actual=%h required=%h", observed(), 30'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        send(make_good(16'h00BB));
        checks++;
        if (observed() !== expected(1'b1)) begin
            failures++;
            $display("FAIL after_reset actual=%h required=%h", observed(), expected(1'b1));
        end
    endtask

    initial begin
        rst = 1'b1;
        rawData = 16'h0000;
        frameValid = 1'b0;
        model_clear();
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
